// File: rtl/axis_measure_top_if.sv
// Bus interfaces for axis_measure_top.
//  axis_measure_lite_if   : AXI4-Lite control/status channel (32-bit address and data).
//    master drives aw*/w*/ar* payload+valid and bready/rready; slave drives the readies,
//    bvalid/bresp and rvalid/rdata/rresp.
//  axis_measure_stream_if : AXI4-Stream tdata/tvalid/tready; DATA_WIDTH is in bytes.
interface axis_measure_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axis_measure_stream_if #(
    parameter int unsigned DATA_WIDTH = 4
);
    logic [DATA_WIDTH*8-1:0] tdata;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_measure_top.sv
// AXI4-Stream pass-through probe with an AXI4-Lite control/status slave.
// The stream is forwarded combinationally and never stalled; while recording, the probe
// counts clock cycles and recorded beats and captures the low 32 bits of the last recorded beat.
// Ports:
//  ap_clk, ap_rst_n : clock and asynchronous active-low reset
//  s_axi_control    : AXI4-Lite slave (CONTROL 0x00, CYCLES lo/hi 0x10/0x14, FRAMES 0x18,
//                     LAST_FRAME 0x20)
//  instream         : stream input (slave side)
//  outstream        : stream output (master side)
module axis_measure_top #(
    parameter logic        INITIAL_RECORD_ENABLE = 1'b0,
    parameter logic        RECORD_ONLY_NONZERO   = 1'b0,
    parameter int unsigned DATA_WIDTH            = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    axis_measure_lite_if.slave    s_axi_control,
    axis_measure_stream_if.slave  instream,
    axis_measure_stream_if.master outstream
);

    localparam int unsigned TDATA_W = DATA_WIDTH * 8;
    localparam int unsigned REG_W   = 32;

    // Word indices (byte address >> 2).
    localparam logic [29:0] IDX_CONTROL = 30'h0;
    localparam logic [29:0] IDX_CYC_LO  = 30'h4;
    localparam logic [29:0] IDX_CYC_HI  = 30'h5;
    localparam logic [29:0] IDX_FRAMES  = 30'h6;
    localparam logic [29:0] IDX_LAST    = 30'h8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic              awready_q, wready_q, bvalid_q;
    logic              awready_d, wready_d, bvalid_d;
    logic              arready_q, rvalid_q;
    logic              arready_d, rvalid_d;
    logic [REG_W-1:0]  rdata_q;
    logic [REG_W-1:0]  rd_value_c;
    logic [31:0]       awaddr_q;

    logic              rec;
    logic [63:0]       cycles;
    logic [31:0]       frames;
    logic [REG_W-1:0]  last_frame;

    logic              aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic              ctrl_wr_c, sig_start_c, sig_clear_c, sig_stop_c;
    logic              beat_c, rec_beat_c;
    logic [REG_W-1:0]  beat_word_c;

    // Stream pass-through, zero latency.
    assign outstream.tdata  = instream.tdata;
    assign outstream.tvalid = instream.tvalid;
    assign instream.tready  = outstream.tready;

    // Low 32 bits of the beat, zero-extended for narrow streams.
    if (TDATA_W >= REG_W) begin : g_wide
        assign beat_word_c = instream.tdata[REG_W-1:0];
    end else begin : g_narrow
        assign beat_word_c = REG_W'(instream.tdata);
    end

    assign beat_c     = instream.tvalid & outstream.tready;
    assign rec_beat_c = beat_c & rec & (~RECORD_ONLY_NONZERO | (|instream.tdata));

    // Handshakes qualified by the registered readies/valids.
    assign aw_hs_c = s_axi_control.awvalid & awready_q;
    assign w_hs_c  = s_axi_control.wvalid  & wready_q;
    assign b_hs_c  = s_axi_control.bready  & bvalid_q;
    assign ar_hs_c = s_axi_control.arvalid & arready_q;
    assign r_hs_c  = s_axi_control.rready  & rvalid_q;

    // CONTROL write takes effect on the W handshake; byte 0 strobe gates it.
    assign ctrl_wr_c   = w_hs_c & (awaddr_q[31:2] == IDX_CONTROL) & s_axi_control.wstrb[0];
    assign sig_start_c = ctrl_wr_c & s_axi_control.wdata[0];
    assign sig_clear_c = ctrl_wr_c & s_axi_control.wdata[1];
    assign sig_stop_c  = ctrl_wr_c & s_axi_control.wdata[2];

    // Write channel next state and registered handshake outputs.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs_c) w_next = W_DATA;
            W_DATA:  if (w_hs_c)  w_next = W_RESP;
            W_RESP:  if (b_hs_c)  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        awready_d = (w_next == W_IDLE);
        wready_d  = (w_next == W_DATA);
        bvalid_d  = (w_next == W_RESP);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
        end else begin
            w_state   <= w_next;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            if (aw_hs_c) awaddr_q <= s_axi_control.awaddr;
        end
    end

    // Read data mux; unmapped words read as zero.
    always_comb begin
        rd_value_c = '0;
        unique case (s_axi_control.araddr[31:2])
            IDX_CONTROL: rd_value_c = REG_W'(rec);
            IDX_CYC_LO:  rd_value_c = cycles[31:0];
            IDX_CYC_HI:  rd_value_c = cycles[63:32];
            IDX_FRAMES:  rd_value_c = frames;
            IDX_LAST:    rd_value_c = last_frame;
            default:     rd_value_c = '0;
        endcase
    end

    // Read channel next state and registered handshake outputs.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs_c) r_next = R_DATA;
            R_DATA:  if (r_hs_c)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_DATA);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_next;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            if (ar_hs_c) rdata_q <= rd_value_c;
        end
    end

    // Recording flag: STOP wins over START.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rec <= INITIAL_RECORD_ENABLE;
        end else if (sig_stop_c) begin
            rec <= 1'b0;
        end else if (sig_start_c) begin
            rec <= 1'b1;
        end
    end

    // Measurement counters; CLEAR overrides any same-cycle count or capture.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cycles     <= '0;
            frames     <= '0;
            last_frame <= '0;
        end else if (sig_clear_c) begin
            cycles     <= '0;
            frames     <= '0;
            last_frame <= '0;
        end else begin
            if (rec) cycles <= cycles + 64'd1;
            if (rec_beat_c) begin
                frames     <= frames + 32'd1;
                last_frame <= beat_word_c;
            end
        end
    end

    assign s_axi_control.awready = awready_q;
    assign s_axi_control.wready  = wready_q;
    assign s_axi_control.bvalid  = bvalid_q;
    assign s_axi_control.bresp   = 2'b00;
    assign s_axi_control.arready = arready_q;
    assign s_axi_control.rvalid  = rvalid_q;
    assign s_axi_control.rdata   = rdata_q;
    assign s_axi_control.rresp   = 2'b00;

endmodule

// File: tb/tb_axis_measure_top.sv
// Self-checking bench for axis_measure_top: directed scenarios plus randomized concurrent
// stream/control traffic checked against a register-level reference model.
module tb_axis_measure_top;

    localparam logic        INIT_REC = 1'b1;
    localparam logic        ONLY_NZ  = 1'b1;
    localparam int unsigned DW       = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    axis_measure_lite_if                        axil ();
    axis_measure_stream_if #(.DATA_WIDTH(DW))   in_s ();
    axis_measure_stream_if #(.DATA_WIDTH(DW))   out_s ();

    axis_measure_top #(
        .INITIAL_RECORD_ENABLE(INIT_REC),
        .RECORD_ONLY_NONZERO  (ONLY_NZ),
        .DATA_WIDTH           (DW)
    ) dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .s_axi_control(axil),
        .instream     (in_s),
        .outstream    (out_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (register semantics) ----------------
    logic        m_rec;
    logic [63:0] m_cycles;
    logic [31:0] m_frames;
    logic [31:0] m_last;
    logic [31:0] m_awaddr;
    logic [31:0] m_exp_rdata;

    logic m_rec_beat, m_wr_ctrl, m_start, m_clear, m_stop;
    assign m_rec_beat = in_s.tvalid && out_s.tready && m_rec && (!ONLY_NZ || in_s.tdata != '0);
    assign m_wr_ctrl  = axil.wvalid && axil.wready && (m_awaddr[31:2] == 30'd0) && axil.wstrb[0];
    assign m_start    = m_wr_ctrl && axil.wdata[0];
    assign m_clear    = m_wr_ctrl && axil.wdata[1];
    assign m_stop     = m_wr_ctrl && axil.wdata[2];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (a[31:2])
            30'h0:   return {31'd0, m_rec};
            30'h4:   return m_cycles[31:0];
            30'h5:   return m_cycles[63:32];
            30'h6:   return m_frames;
            30'h8:   return m_last;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rec       <= INIT_REC;
            m_cycles    <= '0;
            m_frames    <= '0;
            m_last      <= '0;
            m_awaddr    <= '0;
            m_exp_rdata <= '0;
        end else begin
            if (axil.awvalid && axil.awready) m_awaddr <= axil.awaddr;
            if (axil.arvalid && axil.arready) m_exp_rdata <= model_rd(axil.araddr);
            m_cycles <= m_clear ? 64'd0 : m_cycles + (m_rec ? 64'd1 : 64'd0);
            m_frames <= m_clear ? 32'd0 : m_frames + (m_rec_beat ? 32'd1 : 32'd0);
            if (m_clear)         m_last <= '0;
            else if (m_rec_beat) m_last <= in_s.tdata;
            if (m_stop)          m_rec <= 1'b0;
            else if (m_start)    m_rec <= 1'b1;
        end
    end

    // ---------------- bus tasks (start and end on a negedge) ----------------
    task automatic axil_read(input logic [31:0] addr, input int rdly, output logic [31:0] data);
        int n;
        logic [31:0] first;
        string tag;
        tag = $sformatf("rd_%0h", addr);
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        n = 0;
        while (!axil.arready && n < 50) begin @(negedge clk); n++; end
        if (!axil.arready) begin
            check_eq({tag, "_arready_timeout"}, 64'(axil.arready), 64'd1);
            axil.arvalid = 1'b0;
            data = '0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        axil.arvalid = 1'b0;
        check_eq({tag, "_rvalid"}, 64'(axil.rvalid), 64'd1);
        first = axil.rdata;
        check_eq({tag, "_rdata"}, 64'(first), 64'(m_exp_rdata));
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check_eq({tag, "_rvalid_hold"}, 64'(axil.rvalid), 64'd1);
            check_eq({tag, "_rdata_stable"}, 64'(axil.rdata), 64'(first));
        end
        check_eq({tag, "_rresp"}, 64'(axil.rresp), 64'd0);
        axil.rready = 1'b1;
        @(negedge clk);
        axil.rready = 1'b0;
        check_eq({tag, "_rvalid_clr"}, 64'(axil.rvalid), 64'd0);
        data = first;
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int gap, input int bdly);
        int n;
        string tag;
        tag = $sformatf("wr_%0h", addr);
        axil.awaddr  = addr;
        axil.awvalid = 1'b1;
        n = 0;
        while (!axil.awready && n < 50) begin @(negedge clk); n++; end
        if (!axil.awready) begin
            check_eq({tag, "_awready_timeout"}, 64'(axil.awready), 64'd1);
            axil.awvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        axil.awvalid = 1'b0;
        repeat (gap) @(negedge clk);
        axil.wdata  = data;
        axil.wstrb  = strb;
        axil.wvalid = 1'b1;
        n = 0;
        while (!axil.wready && n < 50) begin @(negedge clk); n++; end
        if (!axil.wready) begin
            check_eq({tag, "_wready_timeout"}, 64'(axil.wready), 64'd1);
            axil.wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        axil.wvalid = 1'b0;
        check_eq({tag, "_bvalid"}, 64'(axil.bvalid), 64'd1);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check_eq({tag, "_bvalid_hold"}, 64'(axil.bvalid), 64'd1);
        end
        check_eq({tag, "_bresp"}, 64'(axil.bresp), 64'd0);
        axil.bready = 1'b1;
        @(negedge clk);
        axil.bready = 1'b0;
        check_eq({tag, "_bvalid_clr"}, 64'(axil.bvalid), 64'd0);
    endtask

    // One beat, with 'stall' cycles of downstream back-pressure first.
    task automatic send_beat(input logic [31:0] d, input int stall);
        in_s.tdata  = d;
        in_s.tvalid = 1'b1;
        out_s.tready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            #1;
            check_eq("stall_in_tready", 64'(in_s.tready), 64'd0);
            check_eq("stall_out_tvalid", 64'(out_s.tvalid), 64'd1);
            @(negedge clk);
        end
        out_s.tready = 1'b1;
        #1;
        check_eq("pass_tdata", 64'(out_s.tdata), 64'(d));
        check_eq("pass_tready", 64'(in_s.tready), 64'd1);
        @(negedge clk);
        in_s.tvalid  = 1'b0;
        in_s.tdata   = $urandom;
        out_s.tready = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd, c1, c2;
    logic [31:0] rd_addrs [9] = '{32'h00, 32'h10, 32'h14, 32'h18, 32'h20,
                                  32'h08, 32'h24, 32'h03, 32'h1A};
    int n;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
        axil.wvalid = 1'b0; axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b0;
        in_s.tdata = '0; in_s.tvalid = 1'b0; out_s.tready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 64'(axil.awready), 64'd0);
        check_eq("rst_arready", 64'(axil.arready), 64'd0);
        check_eq("rst_bvalid", 64'(axil.bvalid), 64'd0);
        check_eq("rst_rdata", 64'(axil.rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_awready", 64'(axil.awready), 64'd1);
        check_eq("idle_wready", 64'(axil.wready), 64'd0);
        check_eq("idle_arready", 64'(axil.arready), 64'd1);

        // Recording after reset; cycle counter advances one per clock.
        axil_read(32'h00, 0, rd);
        check_eq("init_rec", 64'(rd), 64'd1);
        axil_read(32'h10, 0, c1);
        repeat (8) @(negedge clk);
        axil_read(32'h10, 0, c2);
        check_eq("cycles_delta10", 64'(c2 - c1), 64'd10);

        // CLEAR.
        axil_write(32'h00, 32'h2, 4'h1, 0, 0);
        axil_read(32'h18, 0, rd);
        check_eq("clr_frames", 64'(rd), 64'd0);
        axil_read(32'h20, 0, rd);
        check_eq("clr_last", 64'(rd), 64'd0);
        axil_read(32'h10, 0, rd);

        // Nonzero-only recording.
        send_beat(32'd0, 0);  send_beat(32'd0, 0);  send_beat(32'd10, 0);
        send_beat(32'd5, 0);  send_beat(32'd20, 0); send_beat(32'd30, 0);
        axil_read(32'h18, 0, rd);
        check_eq("nz_frames", 64'(rd), 64'd4);
        axil_read(32'h20, 0, rd);
        check_eq("nz_last", 64'(rd), 64'd30);

        // STOP freezes everything.
        axil_write(32'h00, 32'h4, 4'h1, 0, 0);
        send_beat(32'd7, 0);
        axil_read(32'h18, 0, rd);
        check_eq("stop_frames", 64'(rd), 64'd4);
        axil_read(32'h20, 0, rd);
        check_eq("stop_last", 64'(rd), 64'd30);
        axil_read(32'h00, 0, rd);
        check_eq("stop_rec", 64'(rd), 64'd0);
        axil_read(32'h10, 0, c1);
        axil_read(32'h10, 0, c2);
        check_eq("stop_cycles_frozen", 64'(c2), 64'(c1));

        // Back-pressure: stalled beat counts once.
        axil_write(32'h00, 32'h1, 4'h1, 0, 0);
        send_beat(32'd9, 3);
        axil_read(32'h18, 0, rd);
        check_eq("stall_frames", 64'(rd), 64'd5);

        // Slow W and B phases, slow R phase; byte-0 strobe gating; STOP beats START.
        axil_write(32'h00, 32'h2, 4'h1, 3, 5);
        axil_read(32'h18, 4, rd);
        axil_write(32'h00, 32'h4, 4'he, 1, 2);
        axil_read(32'h00, 0, rd);
        check_eq("strb_gate_rec", 64'(rd), 64'd1);
        axil_write(32'h00, 32'h5, 4'h1, 0, 0);
        axil_read(32'h00, 0, rd);
        check_eq("stop_over_start", 64'(rd), 64'd0);
        axil_write(32'h00, 32'h3, 4'hf, 0, 0);
        axil_read(32'h00, 0, rd);
        check_eq("start_clear_rec", 64'(rd), 64'd1);
        axil_write(32'h18, 32'hffff, 4'hf, 0, 0);
        axil_read(32'h14, 0, rd);
        axil_read(32'h24, 0, rd);
        check_eq("unmapped_rd", 64'(rd), 64'd0);

        // Randomized concurrent stream and control traffic.
        for (int it = 0; it < 60; it++) begin
            int nb, kind, off;
            nb   = $urandom_range(0, 4);
            kind = $urandom_range(0, 3);
            off  = $urandom_range(0, 3);
            fork
                begin
                    for (int b = 0; b < nb; b++) begin
                        logic [31:0] d;
                        d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                        send_beat(d, $urandom_range(0, 2));
                    end
                end
                begin
                    logic [31:0] r;
                    repeat (off) @(negedge clk);
                    case (kind)
                        0: axil_write(32'h00, 32'($urandom_range(0, 7)),
                                      ($urandom_range(0, 3) == 0) ? 4'he : 4'h1,
                                      $urandom_range(0, 2), $urandom_range(0, 2));
                        1: axil_write(rd_addrs[$urandom_range(1, 8)], $urandom, 4'hf,
                                      $urandom_range(0, 2), $urandom_range(0, 2));
                        default: axil_read(rd_addrs[$urandom_range(0, 8)],
                                           $urandom_range(0, 3), r);
                    endcase
                end
            join
        end
        axil_read(32'h18, 0, rd);
        axil_read(32'h20, 0, rd);
        axil_read(32'h10, 0, rd);

        // Reset in the middle of a pending read and a pending write response.
        axil.araddr = 32'h10;
        axil.arvalid = 1'b1;
        n = 0;
        while (!axil.arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        axil.arvalid = 1'b0;
        check_eq("pend_rvalid", 64'(axil.rvalid), 64'd1);
        axil.awaddr = 32'h00;
        axil.awvalid = 1'b1;
        n = 0;
        while (!axil.awready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        axil.awvalid = 1'b0;
        axil.wdata = 32'h4;
        axil.wstrb = 4'h1;
        axil.wvalid = 1'b1;
        n = 0;
        while (!axil.wready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        axil.wvalid = 1'b0;
        check_eq("pend_bvalid", 64'(axil.bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_bvalid", 64'(axil.bvalid), 64'd0);
        check_eq("mid_rst_rvalid", 64'(axil.rvalid), 64'd0);
        check_eq("mid_rst_rdata", 64'(axil.rdata), 64'd0);
        check_eq("mid_rst_awready", 64'(axil.awready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axil_read(32'h00, 0, rd);
        check_eq("post_rst_rec", 64'(rd), 64'd1);
        axil_read(32'h18, 0, rd);
        check_eq("post_rst_frames", 64'(rd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
